// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock-divider controller.
package clk_div_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int MIN_DIV   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/clk_div_core.sv
// Phase counter and divided-waveform generator; also flags the last cycle of each period.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_active,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_clk_out,
  output logic             o_tick,
  output logic             o_boundary
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_next;
  logic             w_boundary;

  assign w_boundary = i_active && (r_cnt == (i_div - DIV_W'(1)));
  assign w_cnt_next = w_boundary ? '0 : r_cnt + DIV_W'(1);
  assign o_boundary = w_boundary;

  // A new period always opens high, since floor(N/2) >= 1 for any legal N.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      o_clk_out <= 1'b0;
      o_tick    <= 1'b0;
    end else if (i_start) begin
      r_cnt     <= '0;
      o_clk_out <= 1'b1;
      o_tick    <= 1'b1;
    end else if (!i_active || i_stop) begin
      r_cnt     <= '0;
      o_clk_out <= 1'b0;
      o_tick    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      o_clk_out <= (w_cnt_next < (i_div >> 1));
      o_tick    <= w_boundary;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: run/drain FSM plus a ratio handshake applied only at period boundaries.
// Optional period counter output enabled by defining CLK_DIV_PERIOD_CNT_EN.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [DIV_W-1:0] div_cur
`ifdef CLK_DIV_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  state_t           r_state;
  logic             r_pending;
  logic [DIV_W-1:0] r_pend_div;
  logic [DIV_W-1:0] r_div_cur;
  logic             r_cfg_err;

  logic w_active;
  logic w_boundary;
  logic w_start;
  logic w_stop;
  logic w_xfer;
  logic w_bad;
  logic w_apply;

  assign w_active = (r_state != IDLE);
  assign w_start  = (r_state == IDLE) && en;
  assign w_stop   = (r_state == DRAIN) && !en && w_boundary;
  assign w_xfer   = cfg_valid && !r_pending;
  assign w_bad    = (cfg_div < DIV_W'(MIN_DIV));
  // A ratio accepted on the final DRAIN boundary lands in IDLE; flush it there.
  assign w_apply  = r_pending && (w_boundary || !w_active);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pending  <= 1'b0;
      r_pend_div <= '0;
      r_div_cur  <= DIV_W'(DEFAULT_DIV);
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= w_xfer && w_bad;
      if (w_apply) begin
        r_div_cur <= r_pend_div;
        r_pending <= 1'b0;
      end
      if (w_xfer && !w_bad) begin
        if (!w_active) begin
          r_div_cur <= cfg_div;
        end else begin
          r_pending  <= 1'b1;
          r_pend_div <= cfg_div;
        end
      end
      case (r_state)
        IDLE:    if (en) r_state <= RUN;
        RUN:     if (!en) r_state <= DRAIN;
        DRAIN: begin
          if (en)              r_state <= RUN;
          else if (w_boundary) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  clk_div_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_stop    (w_stop),
    .i_active  (w_active),
    .i_div     (r_div_cur),
    .o_clk_out (clk_out),
    .o_tick    (tick),
    .o_boundary(w_boundary)
  );

  assign cfg_ready = !r_pending;
  assign cfg_err   = r_cfg_err;
  assign busy      = w_active;
  assign div_cur   = r_div_cur;

`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [15:0] r_period_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_stop) begin
      r_period_cnt <= '0;
    end else if (tick) begin
      r_period_cnt <= r_period_cnt + 16'd1;
    end
  end

  assign period_cnt = r_period_cnt;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with a period-level reference model checked every cycle.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clk_out;
  logic       tick;
  logic       busy;
  logic [7:0] div_cur;
`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .DIV_W      (8),
    .DEFAULT_DIV(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .div_cur   (div_cur)
`ifdef CLK_DIV_PERIOD_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: "am I running, where in the period am I, which ratio".
  bit m_valid = 1'b0;
  bit m_active, m_stop, m_pend, m_err;
  int m_phase, m_n, m_pend_n;

  always @(posedge clk) begin
    bit xfer, at_end;
    if (rst) begin
      m_valid = 1'b1; m_active = 1'b0; m_stop = 1'b0; m_pend = 1'b0;
      m_err = 1'b0; m_phase = 0; m_n = 2; m_pend_n = 0;
    end else if (m_valid) begin
      xfer   = cfg_valid && !m_pend;
      at_end = m_active && (m_phase == m_n - 1);
      m_err  = xfer && (cfg_div < 2);
      if (m_pend && (at_end || !m_active)) begin
        m_n = m_pend_n; m_pend = 1'b0;
      end
      if (xfer && cfg_div >= 2) begin
        if (!m_active) m_n = int'(cfg_div);
        else begin m_pend = 1'b1; m_pend_n = int'(cfg_div); end
      end
      if (!m_active) begin
        if (en) begin m_active = 1'b1; m_phase = 0; m_stop = 1'b0; end
      end else if (m_stop && !en && at_end) begin
        m_active = 1'b0; m_phase = 0; m_stop = 1'b0;
      end else begin
        m_phase = at_end ? 0 : m_phase + 1;
        m_stop  = !en;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_clk_out",   int'(clk_out),   int'(m_active && (m_phase < m_n / 2)));
      chk("m_tick",      int'(tick),      int'(m_active && (m_phase == 0)));
      chk("m_busy",      int'(busy),      int'(m_active));
      chk("m_div_cur",   int'(div_cur),   m_n);
      chk("m_cfg_ready", int'(cfg_ready), int'(!m_pend));
      chk("m_cfg_err",   int'(cfg_err),   int'(m_err));
    end
  end

  task automatic wait_tick(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tick && k < 64);
    if (!tick) chk("tick_timeout", k, -1);
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 64);
    if (busy) chk("idle_timeout", k, -1);
  endtask

  initial begin
    int         k;
    int         ticks;
    logic [9:0] pat;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_div_cur", int'(div_cur), 2);
    rst = 1'b0;

    // Default N=2: plain toggle, tick every 2 cycles starting the cycle after en.
    en = 1'b1;
    @(negedge clk); chk("s1_clk0", int'(clk_out), 1); chk("s1_tick0", int'(tick), 1);
    @(negedge clk); chk("s1_clk1", int'(clk_out), 0); chk("s1_tick1", int'(tick), 0);
    @(negedge clk); chk("s1_clk2", int'(clk_out), 1); chk("s1_tick2", int'(tick), 1);
    en = 1'b0;
    wait_idle(k);

    // Ratio 5 loaded in IDLE: 2 high, 3 low.
    cfg_valid = 1'b1; cfg_div = 8'd5;
    @(negedge clk); cfg_valid = 1'b0;
    chk("s2_div_cur", int'(div_cur), 5);
    en = 1'b1; pat = '0; ticks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pat   = {pat[8:0], clk_out};
      ticks += int'(tick);
    end
    chk("s2_pattern", int'(pat), int'(10'b1100011000));
    chk("s2_ticks", ticks, 2);

    // Offer 4 on a boundary cycle: must wait a full extra N=5 period.
    cfg_valid = 1'b1; cfg_div = 8'd4;
    @(negedge clk); cfg_valid = 1'b0;
    chk("s3_defer_div", int'(div_cur), 5);
    wait_tick(k); chk("s3_defer_period", k, 5);
    chk("s3_div4", int'(div_cur), 4);
    @(negedge clk); cfg_valid = 1'b1; cfg_div = 8'd3;
    @(negedge clk); cfg_valid = 1'b0;
    chk("s3_ready_low", int'(cfg_ready), 0);
    wait_tick(k); chk("s3_old_period", 2 + k, 4);
    chk("s3_ready_back", int'(cfg_ready), 1);
    chk("s3_div3", int'(div_cur), 3);
    wait_tick(k); chk("s3_new_period_a", k, 3);
    wait_tick(k); chk("s3_new_period_b", k, 3);

    // Illegal ratios are rejected with an error pulse.
    cfg_valid = 1'b1; cfg_div = 8'd1;
    @(negedge clk); cfg_valid = 1'b0;
    chk("s4_err1", int'(cfg_err), 1); chk("s4_div_a", int'(div_cur), 3);
    @(negedge clk); chk("s4_err_clear", int'(cfg_err), 0);
    cfg_valid = 1'b1; cfg_div = 8'd0;
    @(negedge clk); cfg_valid = 1'b0;
    chk("s4_err0", int'(cfg_err), 1); chk("s4_div_b", int'(div_cur), 3);
    wait_tick(k);
    wait_tick(k); chk("s4_period", k, 3);

    // N=6: drop en at cnt=1, re-raise at cnt=3, period unchanged.
    cfg_valid = 1'b1; cfg_div = 8'd6;
    @(negedge clk); cfg_valid = 1'b0;
    wait_tick(k); chk("s5_div6", int'(div_cur), 6);
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    @(negedge clk); en = 1'b1;
    wait_tick(k); chk("s5_rearm_period", 3 + k, 6);
    wait_tick(k); chk("s5_period", k, 6);
    en = 1'b0;
    wait_idle(k); chk("s5_drain_len", k, 6);
    chk("s5_idle_clk", int'(clk_out), 0);
    chk("s5_idle_tick", int'(tick), 0);

    // Reset mid-period with a ratio pending.
    en = 1'b1;
    @(negedge clk);
    @(negedge clk); cfg_valid = 1'b1; cfg_div = 8'd4;
    @(negedge clk); cfg_valid = 1'b0;
    chk("s6_pending", int'(cfg_ready), 0);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    chk("s6_clk_out", int'(clk_out), 0);
    chk("s6_tick", int'(tick), 0);
    chk("s6_busy", int'(busy), 0);
    chk("s6_ready", int'(cfg_ready), 1);
    chk("s6_div", int'(div_cur), 2);
    chk("s6_err", int'(cfg_err), 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("s6_discarded", int'(div_cur), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Programmable clock-divider controller that generates a divided clock-enable waveform from the system clock. It accepts divide-ratio updates through a valid/ready handshake and applies them only at output-period boundaries, so no runt or stretched phase is produced. It starts and stops the output cleanly under an enable input. It sits between the configuration register block and every consumer that needs a slow, glitch-free divided strobe or clock.

## Interface
Parameters:
- DIV_W, 8, width of the divide ratio.
- DEFAULT_DIV, 2, ratio loaded at reset; must be ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  run request; level-sensitive.
- cfg_valid  in  1  new ratio offered.
- cfg_div  in  DIV_W  requested ratio N.
- cfg_ready  out  1  controller can accept a ratio.
- cfg_err  out  1  one-cycle pulse: the offered ratio was rejected.
- clk_out  out  1  divided output, registered.
- tick  out  1  one-cycle pulse coincident with each clk_out rising edge.
- busy  out  1  high whenever state ≠ IDLE.
- div_cur  out  DIV_W  ratio currently in effect.

## Operation
- **Ratio and waveform.**
  - Ratio N ≥ 2.
  - Phase counter cnt runs 0..N-1 and wraps.
  - clk_out = 1 when cnt < floor(N/2), otherwise 0. N=2 therefore gives a plain toggle; N=3 gives 1 cycle high, 2 cycles low.
- **States.**
  - IDLE: cnt=0, clk_out=0.
    - en=1 → RUN.
  - RUN: cnt advances every clk.
    - en=0 → DRAIN.
  - DRAIN: cnt keeps advancing.
    - On the boundary cycle (cnt=N-1), go to IDLE.
    - en=1 while in DRAIN → RUN, with no gap and no phase reset.
- **Config handshake.**
  - A transfer occurs when cfg_valid & cfg_ready.
  - cfg_ready = !pending.
  - If cfg_div < 2: no state change, and cfg_err pulses the next cycle.
  - Valid transfer while IDLE: div_cur updates the next cycle.
  - Valid transfer while RUN or DRAIN: the value is latched as pending and cfg_ready drops. At the next boundary cycle, div_cur takes the pending value, pending clears, and cfg_ready rises on the following cycle.
  - A transfer accepted on a boundary cycle applies at the following boundary, not the current one.
- **Reset.** Takes effect at any time, including mid-period or with a ratio pending. Reset values:
  - state IDLE, cnt=0
  - clk_out=0, tick=0, busy=0, cfg_err=0
  - cfg_ready=1, pending cleared
  - div_cur=DEFAULT_DIV

## Timing
- **Start.** en sampled high in IDLE at edge t gives, from edge t+1:
  - state RUN, cnt=0
  - clk_out=1, tick=1, busy=1
- **Period.** tick fires every N cycles: on every cycle where cnt returns to 0 while in RUN.
- **Stop.** en sampled low in RUN: the current period completes. The cycle after the boundary has clk_out=0, busy=0, tick=0.
- **Ratio change.** Applies seamlessly. The last period uses the old N; the next cycle has cnt=0, clk_out=1, tick=1 and the new N.
- **Latency.**
  - cfg transfer to div_cur change: 1 cycle in IDLE.
  - cfg transfer to div_cur change: ≤ N_old cycles in RUN or DRAIN.
- **Simultaneous events.** At a boundary in DRAIN with a pending ratio, the ratio is applied and then IDLE is entered.

## Configuration
- Macro CLK_DIV_PERIOD_CNT_EN, when defined:
  - Adds output port period_cnt (out, 16 bits).
  - period_cnt increments on each tick and wraps from 0xFFFF to 0.
  - It clears on rst or on entry to IDLE.
- When the macro is undefined, the port and its counter are absent. All other behaviour is identical.

## Structure
- Package clk_div_pkg holds:
  - the state enum (IDLE, RUN, DRAIN)
  - constant MIN_DIV = 2
  - the default DIV_W
- Sub-module clk_div_core holds cnt, the clk_out/tick generation and the boundary flag.
- The top level holds the FSM, the config handshake and the pending register.

## Test plan
- Reset, then en=1 with DEFAULT_DIV=2 → clk_out toggles every cycle and tick fires every 2 cycles, starting the cycle after en.
- In IDLE, offer cfg_div=5, then en=1 → clk_out shows 2 cycles high, 3 low, and tick fires every 5 cycles.
- Running at N=4, offer cfg_div=3 mid-period → cfg_ready=0 until the boundary, the current period completes at 4 cycles, and all subsequent periods are 3 cycles.
- Offer cfg_div=1, then cfg_div=0 → cfg_err pulses each time, and div_cur and the waveform are unchanged.
- Running at N=6, drop en at cnt=1, then raise en at cnt=3 → no gap and the period stays 6. Drop en again → IDLE after the boundary with clk_out=0.
- Assert rst at cnt=2 with a ratio pending → all outputs take their reset values the next cycle and the pending ratio is discarded.
